lsu_ctrl: RTL and testbench
===========================

# lsu_ctrl

Multi-cycle load/store controller that sits directly upstream of the data memory. It accepts one load or store request from the CPU through a valid/ready handshake and drives the data memory's address, write-data, memop and write-enable inputs. Aligned accesses pass through as a single memory operation. Misaligned halfword/word accesses are split into consecutive byte operations, and load bytes are reassembled with sign or zero extension.

## Interface
Parameters:
- none; all widths fixed at 32-bit address/data, 3-bit memop.

Ports:
- `clk` in 1: single clock. The data memory's `rdclk`/`wrclk` are tied to it.
- `rstn` in 1: asynchronous, active-low reset.
- `req_valid` in 1: request present.
- `req_ready` out 1: controller idle, can accept a request.
- `req_we` in 1: 1 = store, 0 = load.
- `req_memop` in 3: 000 b, 001 h, 010 w, 100 bu, 101 hu.
- `req_addr` in 32: byte address.
- `req_wdata` in 32: store data, right-aligned.
- `rsp_valid` out 1: one-cycle completion pulse. The consumer always accepts it.
- `rsp_rdata` out 32: load result. 0 for stores and errors.
- `rsp_err` out 1: illegal request, no memory access performed.
- `mem_addr` out 32: to data memory `addr`.
- `mem_datain` out 32: to data memory `datain`.
- `mem_memop` out 3: to data memory `memop`.
- `mem_we` out 1: to data memory `we`.
- `mem_dataout` in 32: from data memory `dataout`. Valid the cycle after the address is presented; byte selection and extension are applied by memop/addr.

## Operation
- **Legality**
  - Stores accept memop 000/001/010 only.
  - Loads accept 000/001/010/100/101.
  - Anything else sets `rsp_err`.
- **Misalignment**
  - h/hu is misaligned when `addr[0]=1`; the access becomes 2 byte ops.
  - w is misaligned when `addr[1:0]!=0`; the access becomes 4 byte ops.
  - Byte accesses are never misaligned.
- **Split ops**
  - Byte k is at `req_addr+k` (32-bit wrap).
  - Stores use memop 000; loads use memop 100.
  - Store byte k drives `mem_datain = {24'b0, req_wdata[8k+7:8k]}`.
  - Load byte k goes to bits [8k+7:8k] of the result.
  - The final result is sign-extended for h and zero-extended for hu; w is unchanged.
- **Aligned ops**
  - Issued once with the original memop, `mem_addr=req_addr`, `mem_datain=req_wdata`.
  - `rsp_rdata` is `mem_dataout` as returned.
- **States**
  - IDLE: `req_ready=1`. On `req_valid`, latch all req fields and set byte counter to 0. Go to RESP if illegal, else ACC.
  - ACC: drive mem signals for the current op.
    - Store: `mem_we=1`. Go to RESP after the last op, else increment the counter and stay in ACC.
    - Load: go to RD.
  - RD: hold `mem_addr`/`mem_memop` unchanged from ACC (the memory output mux depends on them) and capture `mem_dataout`. Go to RESP after the last op, else increment the counter and go to ACC.
  - RESP: `rsp_valid=1` with `rsp_rdata`/`rsp_err`, then go to IDLE.
- **Signal rules**
  - `req_*` are sampled only on handshake (`req_valid & req_ready`). `req_valid` outside IDLE is ignored.
  - `mem_we` is 1 only in ACC for stores; 0 in IDLE, RD and RESP.
  - In IDLE/RESP all `mem_*` outputs are 0.

## Timing
- Handshake cycle = cycle 0.
- Aligned store: we pulse in cycle 1, `rsp_valid` in cycle 2.
- Aligned load: ACC in cycle 1, RD in cycle 2, `rsp_valid` in cycle 3.
- Misaligned stores: we in cycles 1..N, `rsp_valid` in cycle N+1 (N = 2 or 4).
- Misaligned loads: ACC/RD pairs in cycles 1..2N, `rsp_valid` in cycle 2N+1.
- Illegal request: `rsp_valid` with `rsp_err=1` in cycle 1; `mem_we` never asserted.
- Back-to-back: the next handshake is possible in the cycle after RESP.
- Reset values: state IDLE, counter 0, `req_ready=1` (combinational from IDLE), all other outputs 0.
- Reset mid-operation:
  - Aborts immediately and asynchronously; `mem_we` drops to 0 and no response is produced.
  - Bytes already written stay written; the remaining bytes are untouched.

## Structure
- Package `lsu_pkg`:
  - memop constants (`MEMOP_B`, `MEMOP_H`, `MEMOP_W`, `MEMOP_BU`, `MEMOP_HU`);
  - state enum (IDLE, ACC, RD, RESP);
  - function returning op count (1/2/4) from memop and addr[1:0].
- Sub-module `lsu_assemble`: byte-lane insertion into the 32-bit accumulator plus final sign/zero extension. Used on both split and aligned load paths.

## Test plan
1. Aligned sw addr 0x100, wdata 0xDEADBEEF:
   - cycle 1: `mem_we=1`, memop 010, `mem_addr` 0x100;
   - cycle 2: `rsp_valid=1`, `rsp_err=0`, rdata 0.
2. Aligned lh addr 0x102, word at 0x100 = 0x80011234: `rsp_rdata`=0xFFFF8001 in cycle 3.
3. Misaligned lw addr 0x101, bytes 0x101..0x104 = 11, 22, 33, 44:
   - four memop-100 reads at 0x101..0x104;
   - `rsp_rdata`=0x44332211 in cycle 9.
4. Misaligned sh addr 0x203, wdata 0x0000ABCD:
   - sb 0x203 with datain 0xCD in cycle 1;
   - sb 0x204 with datain 0xAB in cycle 2;
   - `rsp_valid` in cycle 3.
   - Then lhu 0x203 returns 0x0000ABCD.
5. Load memop 011, then store memop 100: each gives `rsp_valid`/`rsp_err=1` in cycle 1, `mem_we` stays 0, `req_valid` held during busy cycles is ignored.
6. Misaligned sw 0x301, wdata 0xA1B2C3D4, `rstn` low in cycle 3:
   - outputs are 0 immediately and no `rsp_valid` follows;
   - 0x301=0xD4 and 0x302=0xC3 are written, 0x303/0x304 are unchanged;
   - `req_ready=1` after release.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store controller: memop encodings, FSM states
// and the helpers that decide legality and how many memory operations a request takes.
package lsu_pkg;

  localparam logic [2:0] MEMOP_B  = 3'b000;
  localparam logic [2:0] MEMOP_H  = 3'b001;
  localparam logic [2:0] MEMOP_W  = 3'b010;
  localparam logic [2:0] MEMOP_BU = 3'b100;
  localparam logic [2:0] MEMOP_HU = 3'b101;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    RD   = 2'd2,
    RESP = 2'd3
  } lsu_state_t;

  // Misaligned halfwords take two byte operations and misaligned words take four.
  function automatic logic [2:0] op_count(input logic [2:0] memop, input logic [1:0] addr_lo);
    case (memop)
      MEMOP_H, MEMOP_HU: op_count = addr_lo[0] ? 3'd2 : 3'd1;
      MEMOP_W:           op_count = (addr_lo != 2'b00) ? 3'd4 : 3'd1;
      default:           op_count = 3'd1;
    endcase
  endfunction

  function automatic logic is_legal(input logic we, input logic [2:0] memop);
    case (memop)
      MEMOP_B, MEMOP_H, MEMOP_W: is_legal = 1'b1;
      MEMOP_BU, MEMOP_HU:        is_legal = !we;
      default:                   is_legal = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/lsu_assemble.sv
// Load-result assembly: aligned loads pass the memory word through, split loads
// insert one byte lane per access and get sign/zero extended on the last byte.
module lsu_assemble import lsu_pkg::*; (
  input  logic [31:0] acc_in,
  input  logic [31:0] mem_data,
  input  logic [1:0]  lane,
  input  logic        split,
  input  logic        last,
  input  logic [2:0]  memop,
  output logic [31:0] acc_out
);

  logic [31:0] ins;

  always_comb begin
    ins = acc_in;
    ins[{lane, 3'b000} +: 8] = mem_data[7:0];
    acc_out = mem_data;
    if (split) begin
      acc_out = ins;
      if (last) begin
        case (memop)
          MEMOP_H:  acc_out = {{16{ins[15]}}, ins[15:0]};
          MEMOP_HU: acc_out = {16'h0000, ins[15:0]};
          default:  acc_out = ins;
        endcase
      end
    end
  end

endmodule

// File: rtl/lsu_ctrl.sv
// Load/store controller in front of the data memory: one request at a time,
// misaligned halfword/word accesses are broken into consecutive byte accesses.
module lsu_ctrl import lsu_pkg::*; (
  input  logic        clk,
  input  logic        rstn,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_memop,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_datain,
  output logic [2:0]  mem_memop,
  output logic        mem_we,
  input  logic [31:0] mem_dataout
);

  lsu_state_t  state_q, state_d;
  logic [1:0]  cnt;
  logic [2:0]  nops;
  logic        op_we;
  logic        op_err;
  logic [2:0]  op_memop;
  logic [31:0] op_addr;
  logic [31:0] op_wdata;
  logic [31:0] acc;
  logic [31:0] acc_next;

  logic        latch;
  logic        cnt_inc;
  logic        capture;
  logic        split;
  logic        last;
  logic [7:0]  wbyte;
  logic [31:0] cur_addr;
  logic [31:0] cur_datain;
  logic [2:0]  cur_memop;

  assign split      = (nops != 3'd1);
  assign last       = (({1'b0, cnt} + 3'd1) == nops);
  assign wbyte      = op_wdata[{cnt, 3'b000} +: 8];
  assign cur_addr   = op_addr + {30'd0, cnt};
  assign cur_memop  = split ? (op_we ? MEMOP_B : MEMOP_BU) : op_memop;
  assign cur_datain = split ? {24'h000000, wbyte} : op_wdata;

  lsu_assemble u_assemble (
    .acc_in  (acc),
    .mem_data(mem_dataout),
    .lane    (cnt),
    .split   (split),
    .last    (last),
    .memop   (op_memop),
    .acc_out (acc_next)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q  <= IDLE;
      cnt      <= 2'd0;
      nops     <= 3'd1;
      op_we    <= 1'b0;
      op_err   <= 1'b0;
      op_memop <= 3'd0;
      op_addr  <= 32'd0;
      op_wdata <= 32'd0;
      acc      <= 32'd0;
    end else begin
      state_q <= state_d;
      if (latch) begin
        cnt      <= 2'd0;
        nops     <= op_count(req_memop, req_addr[1:0]);
        op_we    <= req_we;
        op_err   <= !is_legal(req_we, req_memop);
        op_memop <= req_memop;
        op_addr  <= req_addr;
        op_wdata <= req_wdata;
        acc      <= 32'd0;
      end else begin
        if (cnt_inc) cnt <= cnt + 2'd1;
        if (capture) acc <= acc_next;
      end
    end
  end

  // RD keeps the ACC address/memop on the bus because the memory's output mux still uses them.
  always_comb begin
    state_d    = state_q;
    req_ready  = 1'b0;
    rsp_valid  = 1'b0;
    rsp_err    = 1'b0;
    rsp_rdata  = 32'd0;
    mem_addr   = 32'd0;
    mem_datain = 32'd0;
    mem_memop  = 3'd0;
    mem_we     = 1'b0;
    latch      = 1'b0;
    cnt_inc    = 1'b0;
    capture    = 1'b0;
    case (state_q)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          latch   = 1'b1;
          state_d = is_legal(req_we, req_memop) ? ACC : RESP;
        end
      end
      ACC: begin
        mem_addr   = cur_addr;
        mem_datain = cur_datain;
        mem_memop  = cur_memop;
        mem_we     = op_we;
        if (!op_we) begin
          state_d = RD;
        end else if (last) begin
          state_d = RESP;
        end else begin
          cnt_inc = 1'b1;
        end
      end
      RD: begin
        mem_addr   = cur_addr;
        mem_datain = cur_datain;
        mem_memop  = cur_memop;
        capture    = 1'b1;
        if (last) begin
          state_d = RESP;
        end else begin
          cnt_inc = 1'b1;
          state_d = ACC;
        end
      end
      RESP: begin
        rsp_valid = 1'b1;
        rsp_err   = op_err;
        rsp_rdata = acc;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_lsu_ctrl.sv
// Directed bench for lsu_ctrl with a byte-addressed data memory model:
// synchronous read word, combinational lane select/extension by memop and addr.
module tb_lsu_ctrl;
  import lsu_pkg::*;

  logic        clk = 1'b0;
  logic        rstn = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [2:0]  req_memop = 3'd0;
  logic [31:0] req_addr = 32'd0;
  logic [31:0] req_wdata = 32'd0;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic [31:0] mem_addr;
  logic [31:0] mem_datain;
  logic [2:0]  mem_memop;
  logic        mem_we;
  logic [31:0] mem_dataout;

  int vectors = 0;
  int miscompares = 0;

  lsu_ctrl dut (
    .clk        (clk),
    .rstn       (rstn),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_memop  (req_memop),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .rsp_valid  (rsp_valid),
    .rsp_rdata  (rsp_rdata),
    .rsp_err    (rsp_err),
    .mem_addr   (mem_addr),
    .mem_datain (mem_datain),
    .mem_memop  (mem_memop),
    .mem_we     (mem_we),
    .mem_dataout(mem_dataout)
  );

  always #5 clk = ~clk;

  // Data memory model
  logic [7:0]  mem [0:1023];
  logic [31:0] rdword = 32'd0;
  logic        pre_we = 1'b0;
  logic [9:0]  pre_addr = 10'd0;
  logic [7:0]  pre_data = 8'd0;
  logic [9:0]  a0, a1, a2, a3, wa;
  logic [31:0] sh;

  assign a0 = mem_addr[9:0];
  assign a1 = a0 + 10'd1;
  assign a2 = a0 + 10'd2;
  assign a3 = a0 + 10'd3;
  assign wa = {mem_addr[9:2], 2'b00};
  assign sh = rdword >> {mem_addr[1:0], 3'b000};

  always @(posedge clk) begin
    if (pre_we) begin
      mem[pre_addr] <= pre_data;
    end else if (mem_we) begin
      case (mem_memop)
        MEMOP_B: mem[a0] <= mem_datain[7:0];
        MEMOP_H: begin
          mem[a0] <= mem_datain[7:0];
          mem[a1] <= mem_datain[15:8];
        end
        MEMOP_W: begin
          mem[a0] <= mem_datain[7:0];
          mem[a1] <= mem_datain[15:8];
          mem[a2] <= mem_datain[23:16];
          mem[a3] <= mem_datain[31:24];
        end
        default: ;
      endcase
    end
    rdword <= {mem[wa + 10'd3], mem[wa + 10'd2], mem[wa + 10'd1], mem[wa]};
  end

  always_comb begin
    case (mem_memop)
      MEMOP_B:  mem_dataout = {{24{sh[7]}}, sh[7:0]};
      MEMOP_BU: mem_dataout = {24'd0, sh[7:0]};
      MEMOP_H:  mem_dataout = {{16{sh[15]}}, sh[15:0]};
      MEMOP_HU: mem_dataout = {16'd0, sh[15:0]};
      MEMOP_W:  mem_dataout = rdword;
      default:  mem_dataout = 32'd0;
    endcase
  end

  task automatic preload(input logic [9:0] a, input logic [7:0] d);
    @(negedge clk);
    pre_we = 1'b1;
    pre_addr = a;
    pre_data = d;
    @(negedge clk);
    pre_we = 1'b0;
  endtask

  // Presents a request at the negedge of the handshake cycle (cycle 0).
  task automatic issue(input logic we, input logic [2:0] op, input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    req_we = we;
    req_memop = op;
    req_addr = a;
    req_wdata = d;
    req_valid = 1'b1;
  endtask

  task automatic test_reset;
    #1 rstn = 1'b0;
    #2;
    vectors++;
    if ({req_ready, rsp_valid, rsp_err, rsp_rdata, mem_addr, mem_datain, mem_memop, mem_we} !==
        {1'b1, 1'b0, 1'b0, 32'd0, 32'd0, 32'd0, 3'd0, 1'b0}) begin
      miscompares++;
      $display("[TB] FAIL reset_outputs: got ready=%b vld=%b err=%b rd=%h addr=%h din=%h op=%b we=%b, want ready=1 and all else 0",
               req_ready, rsp_valid, rsp_err, rsp_rdata, mem_addr, mem_datain, mem_memop, mem_we);
    end
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
    vectors++;
    if ({req_ready, rsp_valid, mem_we} !== 3'b100) begin
      miscompares++;
      $display("[TB] FAIL reset_release: got ready/vld/we=%b, want 100", {req_ready, rsp_valid, mem_we});
    end
  endtask

  task automatic test_aligned_store;
    issue(1'b1, MEMOP_W, 32'h100, 32'hDEADBEEF);
    vectors++;
    if (req_ready !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL sw_ready: got %b, want 1", req_ready);
    end
    @(negedge clk); req_valid = 1'b0;
    vectors++;
    if ({mem_we, mem_memop, mem_addr, mem_datain, rsp_valid} !== {1'b1, 3'b010, 32'h100, 32'hDEADBEEF, 1'b0}) begin
      miscompares++;
      $display("[TB] FAIL sw_cycle1: got we=%b op=%b addr=%h din=%h vld=%b, want 1 010 00000100 deadbeef 0",
               mem_we, mem_memop, mem_addr, mem_datain, rsp_valid);
    end
    @(negedge clk);
    vectors++;
    if ({rsp_valid, rsp_err, rsp_rdata, mem_we} !== {1'b1, 1'b0, 32'd0, 1'b0}) begin
      miscompares++;
      $display("[TB] FAIL sw_resp: got vld=%b err=%b rd=%h we=%b, want 1 0 00000000 0", rsp_valid, rsp_err, rsp_rdata, mem_we);
    end
    vectors++;
    if ({mem[10'h103], mem[10'h102], mem[10'h101], mem[10'h100]} !== 32'hDEADBEEF) begin
      miscompares++;
      $display("[TB] FAIL sw_memory: got %h, want deadbeef", {mem[10'h103], mem[10'h102], mem[10'h101], mem[10'h100]});
    end
  endtask

  task automatic test_aligned_load;
    preload(10'h100, 8'h34);
    preload(10'h101, 8'h12);
    preload(10'h102, 8'h01);
    preload(10'h103, 8'h80);
    issue(1'b0, MEMOP_H, 32'h102, 32'd0);
    @(negedge clk); req_valid = 1'b0;
    vectors++;
    if ({mem_we, mem_memop, mem_addr} !== {1'b0, 3'b001, 32'h102}) begin
      miscompares++;
      $display("[TB] FAIL lh_acc: got we=%b op=%b addr=%h, want 0 001 00000102", mem_we, mem_memop, mem_addr);
    end
    @(negedge clk);
    vectors++;
    if ({mem_we, mem_memop, mem_addr, rsp_valid} !== {1'b0, 3'b001, 32'h102, 1'b0}) begin
      miscompares++;
      $display("[TB] FAIL lh_rd: got we=%b op=%b addr=%h vld=%b, want 0 001 00000102 0", mem_we, mem_memop, mem_addr, rsp_valid);
    end
    @(negedge clk);
    vectors++;
    if ({rsp_valid, rsp_err, rsp_rdata} !== {1'b1, 1'b0, 32'hFFFF8001}) begin
      miscompares++;
      $display("[TB] FAIL lh_resp: got vld=%b err=%b rd=%h, want 1 0 ffff8001", rsp_valid, rsp_err, rsp_rdata);
    end
  endtask

  task automatic test_busy_ignore;
    preload(10'h100, 8'h78);
    preload(10'h101, 8'h56);
    preload(10'h102, 8'h34);
    preload(10'h103, 8'h12);
    issue(1'b0, MEMOP_W, 32'h100, 32'd0);
    @(negedge clk);
    req_we = 1'b1;
    req_wdata = 32'hCAFEF00D;
    for (int c = 1; c <= 2; c++) begin
      vectors++;
      if ({mem_we, req_ready, rsp_valid} !== 3'b000) begin
        miscompares++;
        $display("[TB] FAIL busy_cycle%0d: got we/ready/vld=%b, want 000", c, {mem_we, req_ready, rsp_valid});
      end
      @(negedge clk);
    end
    req_valid = 1'b0;
    vectors++;
    if ({rsp_valid, rsp_err, rsp_rdata} !== {1'b1, 1'b0, 32'h12345678}) begin
      miscompares++;
      $display("[TB] FAIL busy_resp: got vld=%b err=%b rd=%h, want 1 0 12345678", rsp_valid, rsp_err, rsp_rdata);
    end
    @(negedge clk);
    vectors++;
    if ({req_ready, rsp_valid, mem_we} !== 3'b100) begin
      miscompares++;
      $display("[TB] FAIL busy_after: got ready/vld/we=%b, want 100", {req_ready, rsp_valid, mem_we});
    end
  endtask

  task automatic test_misaligned_load;
    preload(10'h101, 8'h11);
    preload(10'h102, 8'h22);
    preload(10'h103, 8'h33);
    preload(10'h104, 8'h44);
    issue(1'b0, MEMOP_W, 32'h101, 32'd0);
    @(negedge clk); req_valid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      vectors++;
      if ({mem_we, mem_memop, mem_addr} !== {1'b0, 3'b100, 32'h101 + k}) begin
        miscompares++;
        $display("[TB] FAIL lw_split_acc%0d: got we=%b op=%b addr=%h, want 0 100 %h", k, mem_we, mem_memop, mem_addr, 32'h101 + k);
      end
      @(negedge clk);
      vectors++;
      if ({mem_we, mem_memop, mem_addr, rsp_valid} !== {1'b0, 3'b100, 32'h101 + k, 1'b0}) begin
        miscompares++;
        $display("[TB] FAIL lw_split_rd%0d: got we=%b op=%b addr=%h vld=%b", k, mem_we, mem_memop, mem_addr, rsp_valid);
      end
      @(negedge clk);
    end
    vectors++;
    if ({rsp_valid, rsp_err, rsp_rdata} !== {1'b1, 1'b0, 32'h44332211}) begin
      miscompares++;
      $display("[TB] FAIL lw_split_resp: got vld=%b err=%b rd=%h, want 1 0 44332211", rsp_valid, rsp_err, rsp_rdata);
    end
  endtask

  task automatic test_misaligned_store;
    preload(10'h202, 8'h5A);
    preload(10'h203, 8'h00);
    preload(10'h204, 8'h00);
    preload(10'h205, 8'h5A);
    issue(1'b1, MEMOP_H, 32'h203, 32'h0000ABCD);
    @(negedge clk); req_valid = 1'b0;
    vectors++;
    if ({mem_we, mem_memop, mem_addr, mem_datain} !== {1'b1, 3'b000, 32'h203, 32'h000000CD}) begin
      miscompares++;
      $display("[TB] FAIL sh_split_b0: got we=%b op=%b addr=%h din=%h, want 1 000 00000203 000000cd", mem_we, mem_memop, mem_addr, mem_datain);
    end
    @(negedge clk);
    vectors++;
    if ({mem_we, mem_memop, mem_addr, mem_datain} !== {1'b1, 3'b000, 32'h204, 32'h000000AB}) begin
      miscompares++;
      $display("[TB] FAIL sh_split_b1: got we=%b op=%b addr=%h din=%h, want 1 000 00000204 000000ab", mem_we, mem_memop, mem_addr, mem_datain);
    end
    @(negedge clk);
    vectors++;
    if ({rsp_valid, rsp_err, rsp_rdata, mem_we} !== {1'b1, 1'b0, 32'd0, 1'b0}) begin
      miscompares++;
      $display("[TB] FAIL sh_split_resp: got vld=%b err=%b rd=%h we=%b, want 1 0 00000000 0", rsp_valid, rsp_err, rsp_rdata, mem_we);
    end
    vectors++;
    if ({mem[10'h205], mem[10'h204], mem[10'h203], mem[10'h202]} !== 32'h5AABCD5A) begin
      miscompares++;
      $display("[TB] FAIL sh_split_memory: got %h, want 5aabcd5a", {mem[10'h205], mem[10'h204], mem[10'h203], mem[10'h202]});
    end
    issue(1'b0, MEMOP_HU, 32'h203, 32'd0);
    @(negedge clk); req_valid = 1'b0;
    repeat (4) @(negedge clk);
    vectors++;
    if ({rsp_valid, rsp_err, rsp_rdata} !== {1'b1, 1'b0, 32'h0000ABCD}) begin
      miscompares++;
      $display("[TB] FAIL lhu_split_resp: got vld=%b err=%b rd=%h, want 1 0 0000abcd", rsp_valid, rsp_err, rsp_rdata);
    end
    issue(1'b0, MEMOP_H, 32'h203, 32'd0);
    @(negedge clk); req_valid = 1'b0;
    repeat (4) @(negedge clk);
    vectors++;
    if ({rsp_valid, rsp_err, rsp_rdata} !== {1'b1, 1'b0, 32'hFFFFABCD}) begin
      miscompares++;
      $display("[TB] FAIL lh_split_resp: got vld=%b err=%b rd=%h, want 1 0 ffffabcd", rsp_valid, rsp_err, rsp_rdata);
    end
  endtask

  task automatic test_illegal;
    logic [2:0] ops [0:2];
    logic       wes [0:2];
    ops[0] = 3'b011; wes[0] = 1'b0;
    ops[1] = 3'b100; wes[1] = 1'b1;
    ops[2] = 3'b101; wes[2] = 1'b1;
    for (int i = 0; i < 3; i++) begin
      issue(wes[i], ops[i], 32'h100, 32'h55555555);
      @(negedge clk);
      vectors++;
      if ({rsp_valid, rsp_err, rsp_rdata, mem_we, req_ready} !== {1'b1, 1'b1, 32'd0, 1'b0, 1'b0}) begin
        miscompares++;
        $display("[TB] FAIL illegal%0d_resp: got vld=%b err=%b rd=%h we=%b ready=%b, want 1 1 00000000 0 0",
                 i, rsp_valid, rsp_err, rsp_rdata, mem_we, req_ready);
      end
      @(negedge clk);
      req_valid = 1'b0;
      vectors++;
      if ({rsp_valid, mem_we, req_ready} !== 3'b001) begin
        miscompares++;
        $display("[TB] FAIL illegal%0d_after: got vld/we/ready=%b, want 001", i, {rsp_valid, mem_we, req_ready});
      end
    end
  endtask

  task automatic test_back_to_back;
    issue(1'b1, MEMOP_B, 32'h10, 32'h0000009C);
    @(negedge clk); req_valid = 1'b0;
    @(negedge clk);
    vectors++;
    if ({rsp_valid, rsp_err} !== 2'b10) begin
      miscompares++;
      $display("[TB] FAIL b2b_store_resp: got vld/err=%b, want 10", {rsp_valid, rsp_err});
    end
    issue(1'b0, MEMOP_B, 32'h10, 32'd0);
    vectors++;
    if (req_ready !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL b2b_ready: got %b, want 1", req_ready);
    end
    @(negedge clk); req_valid = 1'b0;
    repeat (2) @(negedge clk);
    vectors++;
    if ({rsp_valid, rsp_err, rsp_rdata} !== {1'b1, 1'b0, 32'hFFFFFF9C}) begin
      miscompares++;
      $display("[TB] FAIL b2b_load_resp: got vld=%b err=%b rd=%h, want 1 0 ffffff9c", rsp_valid, rsp_err, rsp_rdata);
    end
  endtask

  task automatic test_reset_mid;
    preload(10'h301, 8'h11);
    preload(10'h302, 8'h22);
    preload(10'h303, 8'h77);
    preload(10'h304, 8'h88);
    issue(1'b1, MEMOP_W, 32'h301, 32'hA1B2C3D4);
    @(negedge clk); req_valid = 1'b0;
    vectors++;
    if ({mem_we, mem_addr, mem_datain} !== {1'b1, 32'h301, 32'h000000D4}) begin
      miscompares++;
      $display("[TB] FAIL rstmid_b0: got we=%b addr=%h din=%h, want 1 00000301 000000d4", mem_we, mem_addr, mem_datain);
    end
    @(negedge clk);
    @(negedge clk);
    vectors++;
    if ({mem_we, mem_addr, mem_datain} !== {1'b1, 32'h303, 32'h000000B2}) begin
      miscompares++;
      $display("[TB] FAIL rstmid_b2: got we=%b addr=%h din=%h, want 1 00000303 000000b2", mem_we, mem_addr, mem_datain);
    end
    rstn = 1'b0;
    #1;
    vectors++;
    if ({req_ready, rsp_valid, rsp_err, rsp_rdata, mem_addr, mem_datain, mem_memop, mem_we} !==
        {1'b1, 1'b0, 1'b0, 32'd0, 32'd0, 32'd0, 3'd0, 1'b0}) begin
      miscompares++;
      $display("[TB] FAIL rstmid_abort: got ready=%b vld=%b we=%b addr=%h din=%h op=%b, want 1 0 0 0 0 0",
               req_ready, rsp_valid, mem_we, mem_addr, mem_datain, mem_memop);
    end
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      vectors++;
      if ({req_ready, rsp_valid, mem_we} !== 3'b100) begin
        miscompares++;
        $display("[TB] FAIL rstmid_release%0d: got ready/vld/we=%b, want 100", c, {req_ready, rsp_valid, mem_we});
      end
    end
    vectors++;
    if ({mem[10'h304], mem[10'h303], mem[10'h302], mem[10'h301]} !== 32'h8877C3D4) begin
      miscompares++;
      $display("[TB] FAIL rstmid_memory: got %h, want 8877c3d4", {mem[10'h304], mem[10'h303], mem[10'h302], mem[10'h301]});
    end
  endtask

  initial begin
    test_reset;
    test_aligned_store;
    test_aligned_load;
    test_busy_ignore;
    test_misaligned_load;
    test_misaligned_store;
    test_illegal;
    test_back_to_back;
    test_reset_mid;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
